// File: rtl/ltl_monitor_pkg.sv
// Shared types for the LTL monitor cluster: collector FSM states and the
// timestamped report record for the default cluster configuration.
package ltl_monitor_pkg;

    localparam int NUM_REPORTS_DEF = 4;
    localparam int IDX_W_DEF       = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        FROZEN = 2'd2
    } collector_state_e;

    typedef struct packed {
        logic [NUM_REPORTS_DEF-1:0] reports;
        logic [IDX_W_DEF-1:0]       index;
    } report_rec_t;

endpackage

// File: rtl/ltl_report_fifo.sv
// Synchronous FIFO for report records; clear flushes it, and a push into a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module ltl_report_fifo
    import ltl_monitor_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = $bits(report_rec_t)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = 1'b0;
        do_push  = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            do_pop  = pop && (count_q != '0);
            do_push = push && ((count_q != FULL_CNT) || do_pop);
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; readers only look at it while count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/ltl_report_collector.sv
// Timestamps non-zero automaton report vectors with their symbol index,
// buffers them and drains them over valid/ready with overflow accounting.
module ltl_report_collector
    import ltl_monitor_pkg::*;
#(
    parameter int NUM_REPORTS = 4,
    parameter int IDX_W       = 32,
    parameter int DEPTH       = 8,
    parameter int DROP_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   arm,
    input  logic                   clear,
    input  logic                   freeze_on_first,
    input  logic [NUM_REPORTS-1:0] reports,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [NUM_REPORTS-1:0] rec_reports,
    output logic [IDX_W-1:0]       rec_index,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count,
    output logic [1:0]             state_o
);

    typedef struct packed {
        logic [NUM_REPORTS-1:0] reports;
        logic [IDX_W-1:0]       index;
    } rec_t;

    collector_state_e      state_q, state_d;
    logic [IDX_W-1:0]      sym_idx_q, sym_idx_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  run_q, run_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_W-1:0]     drop_q, drop_d;
    rec_t                  hold_q, hold_d;

    rec_t                  head;
    rec_t                  wr_rec;
    logic                  fifo_push, fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                  sample, pop_fire, drop;

    assign wr_rec   = '{reports: reports, index: idx_q};
    assign pop_fire = rec_valid && rec_ready;

    always_comb begin
        state_d    = state_q;
        sym_idx_d  = sym_idx_q;
        idx_d      = sym_idx_q;
        run_d      = run;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        hold_d     = fifo_empty ? hold_q : head;
        sample     = (state_q == ARMED) && run_q && (reports != '0);
        fifo_push  = 1'b0;
        drop       = 1'b0;
        if (clear) begin
            state_d    = IDLE;
            sym_idx_d  = '0;
            idx_d      = '0;
            run_d      = 1'b0;
            overflow_d = 1'b0;
            drop_d     = '0;
        end else begin
            fifo_push = sample;
            drop      = sample && fifo_full && !pop_fire;
            case (state_q)
                IDLE: begin
                    if (arm) begin
                        state_d   = ARMED;
                        sym_idx_d = '0;
                    end
                end
                ARMED: begin
                    if (run) sym_idx_d = sym_idx_q + IDX_W'(1);
                    // Freezing happens even when the record itself is dropped.
                    if (sample && freeze_on_first) state_d = FROZEN;
                end
                default: state_d = state_q;
            endcase
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            sym_idx_q  <= '0;
            idx_q      <= '0;
            run_q      <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            sym_idx_q  <= sym_idx_d;
            idx_q      <= idx_d;
            run_q      <= run_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            hold_q     <= hold_d;
        end
    end

    ltl_report_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rec_t))
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear),
        .push    (fifo_push),
        .wr_data (wr_rec),
        .pop     (rec_ready),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // With the FIFO empty the data outputs keep showing the last head seen.
    assign rec_valid   = (fifo_count != '0);
    assign rec_reports = fifo_empty ? hold_q.reports : head.reports;
    assign rec_index   = fifo_empty ? hold_q.index   : head.index;
    assign overflow    = overflow_q;
    assign drop_count  = drop_q;
    assign state_o     = state_q;

endmodule

// File: doc/ltl_report_collector.md
Name: ltl_report_collector

Overview:
- Downstream stage of each monitor cluster automaton.
- Samples the automaton's report vector once per consumed symbol and timestamps each non-zero vector with the index of the symbol that triggered it.
- Buffers these records in a small FIFO and drains them over a valid/ready interface to the violation handler.
- Provides arm/freeze control, overflow detection and saturating drop accounting.

Parameters:
- NUM_REPORTS, 4, width of the report vector (one bit per report STE output).
- IDX_W, 32, width of the symbol-index counter.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  a symbol is consumed by the automaton this cycle (same signal that drives the automaton).
- arm  in  1  one-cycle pulse; leave IDLE and start capturing.
- clear  in  1  synchronous clear of the counters, FIFO, flags and FSM; takes priority over every other input.
- freeze_on_first  in  1  static mode; when 1, stop capturing after the first recorded report.
- reports  in  NUM_REPORTS  automaton report outputs (registered STE active_state).
- rec_valid  out  1  head record available.
- rec_ready  in  1  consumer accepts the head record.
- rec_reports  out  NUM_REPORTS  head record report vector.
- rec_index  out  IDX_W  head record symbol index.
- overflow  out  1  sticky; at least one record was dropped.
- drop_count  out  DROP_W  number of dropped records, saturating.
- state_o  out  2  FSM state, for debug.

Behaviour:
- Reset (reset=0, asynchronous): FSM=IDLE, sym_idx=0, run_q=0, FIFO empty. All outputs 0: rec_valid, rec_reports, rec_index, overflow, drop_count, state_o.
- Alignment: reports reflect the symbol consumed one cycle earlier.
  - run_q is run registered by one cycle.
  - idx_q is the value of sym_idx registered alongside it.
  - Sample point is a cycle with run_q=1.
- sym_idx increments by 1 every cycle run=1 while the FSM is ARMED. It wraps modulo 2^IDX_W with no flag.
- FSM states: IDLE=0, ARMED=1, FROZEN=2.
  - IDLE -> ARMED on arm=1. sym_idx resets to 0 on that same edge.
  - ARMED -> FROZEN on the cycle a record is pushed while freeze_on_first=1.
  - FROZEN holds until clear. arm is ignored in ARMED and FROZEN.
  - clear=1 (any state) -> IDLE, sym_idx=0, FIFO flushed, overflow=0, drop_count=0, run_q=0.
- Capture rule: push {reports, idx_q} when all of the following hold in the same cycle:
  - state=ARMED
  - run_q=1
  - reports != 0
- Samples with run_q=0 or reports==0 are never recorded.
- Full FIFO at a push:
  - record is dropped and overflow is set (sticky).
  - drop_count increments, saturating at 2^DROP_W-1.
  - the FSM transition to FROZEN still occurs.
- Simultaneous push and pop when full: the pop frees a slot, so the push is accepted. No drop.
- Simultaneous push and pop when empty: the record is written. rec_valid rises the next cycle (no combinational bypass).
- Write-to-valid latency is 1 cycle.
- Output handshake:
  - rec_valid=1 while the FIFO is not empty. rec_reports and rec_index show the head entry.
  - Pop on rec_valid & rec_ready.
  - Outputs are stable while rec_valid=1 and rec_ready=0.
  - When the FIFO is empty, the data outputs hold their last value; consumers must ignore them.
- Occupancy count is $clog2(DEPTH)+1 bits. Pointers are $clog2(DEPTH) bits and wrap naturally.
- reset asserted mid-drain: everything returns to reset values immediately. Pending records are lost.

Decomposition:
- Shared package ltl_monitor_pkg holds:
  - enum collector_state_e {IDLE, ARMED, FROZEN} (2-bit).
  - typedef report_rec_t {reports, index}, parameterised via localparam defaults NUM_REPORTS=4, IDX_W=32.
- One natural sub-module: ltl_report_fifo.
  - Synchronous FIFO of report_rec_t with push/pop/full/empty/count.
  - Same async active-low reset.
  - Reused by other clusters.

Test Plan:
- Reset then arm; run=1 for 5 cycles; reports=4'b0100 in the cycle after the 3rd symbol (idx 2) -> exactly one record {0100, 2}; rec_valid=1 one cycle after the push; pops with rec_ready=1.
- freeze_on_first=1; reports nonzero at idx 1 and idx 3 -> one record {.,1}; state_o=2; no second record; arm ignored; clear -> state_o=0, FIFO empty.
- DEPTH=8, rec_ready=0, 11 reporting symbols -> 8 records with idx 0..7, overflow=1, drop_count=3; drain yields idx 0..7 in order.
- FIFO full with rec_ready=1 and a push in the same cycle -> no drop, count stays 8, overflow stays 0.
- reports nonzero while run_q=0, or while IDLE -> no record, sym_idx unchanged.
- reset deasserted→asserted mid-drain with 4 entries -> rec_valid=0 immediately (asynchronous), drop_count=0, state_o=0.
